// File: rtl/audio_codec_i2c_pkg.sv
// Shared types, widths and power-on register table for the audio codec
// I2C write-only responder.
package audio_codec_i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int REG_ADDR_W = 7;
    localparam int REG_DATA_W = 9;
    localparam int NACK_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_BYTE1,
        ST_ACK1,
        ST_BYTE2,
        ST_ACK2,
        ST_WAIT_STOP
    } i2c_state_e;

    // WM8731 power-on values; registers beyond the table come up as zero.
    function automatic logic [REG_DATA_W-1:0] regDefault(input int idx);
        logic [REG_DATA_W-1:0] value;
        case (idx)
            0:       value = 9'h097;
            1:       value = 9'h097;
            2:       value = 9'h079;
            3:       value = 9'h079;
            4:       value = 9'h00A;
            5:       value = 9'h008;
            6:       value = 9'h09F;
            7:       value = 9'h00A;
            8:       value = 9'h000;
            9:       value = 9'h000;
            default: value = '0;
        endcase
        return value;
    endfunction

    // The state that follows an ACK slot once SDA has been released again.
    // Nothing follows ACK2 except a wait for STOP: there is no auto-increment.
    function automatic i2c_state_e ackNextState(input i2c_state_e s);
        i2c_state_e nxt;
        case (s)
            ST_ADDR_ACK: nxt = ST_BYTE1;
            ST_ACK1:     nxt = ST_BYTE2;
            default:     nxt = ST_WAIT_STOP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/i2c_line_monitor.sv
// Brings the asynchronous I2C lines into the clk domain and turns them into
// single-cycle SCL edge, START and STOP events.
module i2c_line_monitor
    import audio_codec_i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] sclSync_q;
    logic [1:0] sdaSync_q;
    logic       sclPrev_q;
    logic       sdaPrev_q;
    logic       sclNow;
    logic       sdaNow;

    // Two-flop synchronizers plus one history flop per line; everything
    // resets to the idle-bus level so no edge is reported coming out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclSync_q <= 2'b11;
            sdaSync_q <= 2'b11;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[0], scl_i};
            sdaSync_q <= {sdaSync_q[0], sda_i};
            sclPrev_q <= sclSync_q[1];
            sdaPrev_q <= sdaSync_q[1];
        end
    end

    assign sclNow    = sclSync_q[1];
    assign sdaNow    = sdaSync_q[1];
    assign sda_o     = sdaNow;
    assign scl_rise  = sclNow & ~sclPrev_q;
    assign scl_fall  = ~sclNow & sclPrev_q;
    assign start_det = sclNow & sclPrev_q & sdaPrev_q & ~sdaNow;
    assign stop_det  = sclNow & sclPrev_q & ~sdaPrev_q & sdaNow;

endmodule

// File: rtl/audio_codec_i2c_responder.sv
// Write-only I2C target holding the codec control registers. A transfer is
// address byte, {reg_addr, data[8]}, data[7:0]; reads of our own address are
// refused and counted.
module audio_codec_i2c_responder
    import audio_codec_i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEVICE_ADDRESS = 7'h1A,
    parameter int                    NUM_REGS       = 10,
    parameter logic [REG_ADDR_W-1:0] RESET_REG_ADDR = 7'h0F
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  I2C_SCLK,
    inout  wire                   I2C_SDAT,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic [REG_DATA_W-1:0] rd_data,
    output logic                  wr_strobe,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [REG_DATA_W-1:0] wr_data,
    output logic [NACK_CNT_W-1:0] nack_count
);

    logic sdaIn;
    logic sclRise;
    logic sclFall;
    logic startDet;
    logic stopDet;

    i2c_state_e            state_q;
    logic [2:0]            bitCount_q;
    logic [6:0]            shift_q;
    logic [REG_ADDR_W-1:0] regAddr_q;
    logic                  dataMsb_q;
    logic                  sdaDrive_q;
    logic                  wrStrobe_q;
    logic [REG_ADDR_W-1:0] wrAddr_q;
    logic [REG_DATA_W-1:0] wrData_q;
    logic [NACK_CNT_W-1:0] nackCount_q;
    logic [REG_DATA_W-1:0] regs_q [NUM_REGS];

    logic [7:0]            byte_d;
    logic                  lastBit;
    logic                  addrInRange;
    logic [REG_DATA_W-1:0] wrValue_d;
    logic [REG_DATA_W-1:0] rdData;

    i2c_line_monitor u_lineMonitor (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (I2C_SCLK),
        .sda_i     (I2C_SDAT),
        .sda_o     (sdaIn),
        .scl_rise  (sclRise),
        .scl_fall  (sclFall),
        .start_det (startDet),
        .stop_det  (stopDet)
    );

    // The byte as it stands once the bit on the current SCL rise is included.
    assign byte_d      = {shift_q, sdaIn};
    assign lastBit     = (bitCount_q == 3'd7);
    assign addrInRange = (32'(regAddr_q) < NUM_REGS);
    assign wrValue_d   = {dataMsb_q, byte_d};

    // Open-drain: we only ever pull low or let go.
    assign I2C_SDAT = sdaDrive_q ? 1'b0 : 1'bz;

    // Protocol FSM, register file and write/NACK reporting in one place so a
    // START or STOP can cleanly abort whatever is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitCount_q  <= '0;
            shift_q     <= '0;
            regAddr_q   <= '0;
            dataMsb_q   <= 1'b0;
            sdaDrive_q  <= 1'b0;
            wrStrobe_q  <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            nackCount_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regDefault(i);
            end
        end else begin
            wrStrobe_q <= 1'b0;
            if (startDet) begin
                state_q    <= ST_ADDR;
                bitCount_q <= '0;
                sdaDrive_q <= 1'b0;
            end else if (stopDet) begin
                state_q    <= ST_IDLE;
                bitCount_q <= '0;
                sdaDrive_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_WAIT_STOP: begin
                    end
                    ST_ADDR: begin
                        if (sclRise) begin
                            shift_q    <= byte_d[6:0];
                            bitCount_q <= bitCount_q + 3'd1;
                            if (lastBit) begin
                                if (byte_d[7:1] != DEVICE_ADDRESS) begin
                                    state_q <= ST_WAIT_STOP;
                                end else if (!byte_d[0]) begin
                                    state_q <= ST_ADDR_ACK;
                                end else begin
                                    state_q <= ST_WAIT_STOP;
                                    if (nackCount_q != '1) begin
                                        nackCount_q <= nackCount_q + 8'd1;
                                    end
                                end
                            end
                        end
                    end
                    ST_BYTE1: begin
                        if (sclRise) begin
                            shift_q    <= byte_d[6:0];
                            bitCount_q <= bitCount_q + 3'd1;
                            if (lastBit) begin
                                regAddr_q <= byte_d[7:1];
                                dataMsb_q <= byte_d[0];
                                state_q   <= ST_ACK1;
                            end
                        end
                    end
                    ST_BYTE2: begin
                        if (sclRise) begin
                            shift_q    <= byte_d[6:0];
                            bitCount_q <= bitCount_q + 3'd1;
                            if (lastBit) begin
                                state_q <= ST_ACK2;
                                if (regAddr_q == RESET_REG_ADDR) begin
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        regs_q[i] <= regDefault(i);
                                    end
                                    wrStrobe_q <= 1'b1;
                                    wrAddr_q   <= regAddr_q;
                                    wrData_q   <= wrValue_d;
                                end else if (addrInRange) begin
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        if (regAddr_q == 7'(i)) begin
                                            regs_q[i] <= wrValue_d;
                                        end
                                    end
                                    wrStrobe_q <= 1'b1;
                                    wrAddr_q   <= regAddr_q;
                                    wrData_q   <= wrValue_d;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                        if (sclFall) begin
                            if (!sdaDrive_q) begin
                                sdaDrive_q <= 1'b1;
                            end else begin
                                sdaDrive_q <= 1'b0;
                                state_q    <= ackNextState(state_q);
                            end
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        sdaDrive_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Local read port; addresses past the register file read as zero.
    always_comb begin
        rdData = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) begin
                rdData = regs_q[i];
            end
        end
    end

    assign rd_data    = rdData;
    assign wr_strobe  = wrStrobe_q;
    assign wr_addr    = wrAddr_q;
    assign wr_data    = wrData_q;
    assign nack_count = nackCount_q;

endmodule

// File: tb/tb_audio_codec_i2c_responder.sv
// Bit-banged I2C initiator against a register-file model of the responder.
`timescale 1ns/1ps
module tb_audio_codec_i2c_responder;
    import audio_codec_i2c_pkg::*;

    localparam int Q = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclLine = 1'b1;
    logic       tbSdaLow = 1'b0;
    wire        sdaBus;
    logic [6:0] rdAddr = '0;
    logic [8:0] rdData;
    logic       wrStrobe;
    logic [6:0] wrAddr;
    logic [8:0] wrData;
    logic [7:0] nackCount;

    assign sdaBus = tbSdaLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    always #5 clk = ~clk;

    audio_codec_i2c_responder dut (
        .clk        (clk),
        .reset      (reset),
        .I2C_SCLK   (sclLine),
        .I2C_SDAT   (sdaBus),
        .rd_addr    (rdAddr),
        .rd_data    (rdData),
        .wr_strobe  (wrStrobe),
        .wr_addr    (wrAddr),
        .wr_data    (wrData),
        .nack_count (nackCount)
    );

    int assertCount = 0;
    int failCount   = 0;
    int strobeCount = 0;
    int driveCount  = 0;

    logic [8:0] model [0:9];
    int         nackModel;
    logic [6:0] lastAddrModel;
    logic [8:0] lastDataModel;

    // Count strobe cycles and cycles where the DUT pulls SDA while we let go.
    always @(negedge clk) begin
        if (wrStrobe === 1'b1) strobeCount++;
        if (!tbSdaLow && sdaBus === 1'b0) driveCount++;
    end

    // Hard stop in case the sequence somehow runs away.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic resetModel();
        model = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        nackModel     = 0;
        lastAddrModel = '0;
        lastDataModel = '0;
    endtask

    function automatic bit modelWrite(input int r, input logic [8:0] d);
        if (r == 15) begin
            model = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        end else if (r < 10) begin
            model[r] = d;
        end else begin
            return 1'b0;
        end
        lastAddrModel = 7'(r);
        lastDataModel = d;
        return 1'b1;
    endfunction

    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    task automatic sendStart();
        tbSdaLow = 1'b0; waitQ();
        sclLine  = 1'b1; waitQ();
        tbSdaLow = 1'b1; waitQ();
        sclLine  = 1'b0; waitQ();
    endtask

    task automatic sendStop();
        tbSdaLow = 1'b1; waitQ();
        sclLine  = 1'b1; waitQ();
        tbSdaLow = 1'b0; waitQ();
    endtask

    task automatic sendBit(input logic b);
        tbSdaLow = ~b; waitQ();
        sclLine  = 1'b1; waitQ(); waitQ();
        sclLine  = 1'b0; waitQ();
    endtask

    task automatic readAck(output logic acked);
        tbSdaLow = 1'b0; waitQ();
        sclLine  = 1'b1; waitQ();
        acked    = (sdaBus === 1'b0);
        waitQ();
        sclLine  = 1'b0; waitQ();
    endtask

    task automatic sendByte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        readAck(acked);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b1, input logic [7:0] b2,
                                 output logic [2:0] acks);
        logic k0, k1, k2;
        sendStart();
        sendByte(a, k0);
        sendByte(b1, k1);
        sendByte(b2, k2);
        sendStop();
        acks = {k0, k1, k2};
    endtask

    task automatic checkAllRegs(input string tag);
        for (int a = 0; a < 12; a++) begin
            rdAddr = 7'(a);
            #1;
            checkOutput($sformatf("%s_rd%0d", tag, a), 32'(rdData), (a < 10) ? 32'(model[a]) : 32'h0);
        end
    endtask

    task automatic checkReport(input string tag);
        checkOutput($sformatf("%s_wrAddr", tag), 32'(wrAddr), 32'(lastAddrModel));
        checkOutput($sformatf("%s_wrData", tag), 32'(wrData), 32'(lastDataModel));
        checkOutput($sformatf("%s_nack", tag), 32'(nackCount), (nackModel > 255) ? 32'd255 : 32'(nackModel));
    endtask

    task automatic doWrite(input int r, input logic [8:0] d, input string tag);
        logic [2:0] acks;
        int         s0;
        bit         expStrobe;
        s0 = strobeCount;
        applyStimulus(8'h34, {7'(r), d[8]}, d[7:0], acks);
        expStrobe = modelWrite(r, d);
        checkOutput($sformatf("%s_acks", tag), 32'(acks), 32'h7);
        checkOutput($sformatf("%s_strobes", tag), 32'(strobeCount - s0), expStrobe ? 32'd1 : 32'd0);
        checkReport(tag);
        checkAllRegs(tag);
    endtask

    logic [2:0] acks;
    logic       k0, k1, k2, k3, k4;
    int         s0, d0, kind, r;
    logic [6:0] a7;
    logic [8:0] d;

    initial begin
        resetModel();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_strobe", 32'(wrStrobe), 32'h0);
        checkOutput("rst_sda", 32'(sdaBus), 32'h1);
        checkReport("rst");
        checkAllRegs("rst");

        $display("[TB] basic write reg 7");
        s0 = strobeCount;
        applyStimulus(8'h34, 8'h0E, 8'h49, acks);
        void'(modelWrite(7, 9'h049));
        checkOutput("w7_acks", 32'(acks), 32'h7);
        checkOutput("w7_strobes", 32'(strobeCount - s0), 32'd1);
        checkOutput("w7_wrAddr", 32'(wrAddr), 32'h07);
        checkOutput("w7_wrData", 32'(wrData), 32'h049);
        checkAllRegs("w7");

        $display("[TB] foreign address");
        s0 = strobeCount; d0 = driveCount;
        applyStimulus(8'h36, 8'h0E, 8'h49, acks);
        checkOutput("foreign_acks", 32'(acks), 32'h0);
        checkOutput("foreign_drive", 32'(driveCount - d0), 32'd0);
        checkOutput("foreign_strobes", 32'(strobeCount - s0), 32'd0);
        checkOutput("foreign_idle", 32'(dut.state_q), 32'(ST_IDLE));

        $display("[TB] read request refused");
        d0 = driveCount;
        sendStart();
        sendByte(8'h35, k0);
        sendByte(8'hA5, k1);
        sendStop();
        nackModel++;
        checkOutput("read_ack", 32'(k0), 32'h0);
        checkOutput("read_after", 32'(k1), 32'h0);
        checkOutput("read_drive", 32'(driveCount - d0), 32'd0);
        checkOutput("read_nack", 32'(nackCount), 32'd1);

        $display("[TB] reset register");
        doWrite(4, 9'h1FF, "w4");
        doWrite(15, 9'h000, "rst15");

        $display("[TB] repeated start aborts");
        s0 = strobeCount;
        sendStart();
        sendByte(8'h34, k0);
        sendByte(8'h08, k1);
        sendStart();
        sendByte(8'h34, k2);
        sendByte(8'h0A, k3);
        sendByte(8'h55, k4);
        sendStop();
        void'(modelWrite(5, 9'h055));
        checkOutput("rs_acks", 32'({k0, k1, k2, k3, k4}), 32'h1F);
        checkOutput("rs_strobes", 32'(strobeCount - s0), 32'd1);
        checkReport("rs");
        checkAllRegs("rs");

        $display("[TB] extra byte refused");
        s0 = strobeCount;
        sendStart();
        sendByte(8'h34, k0);
        sendByte(8'h05, k1);
        sendByte(8'hC3, k2);
        sendByte(8'hFF, k3);
        sendStop();
        void'(modelWrite(2, 9'h1C3));
        checkOutput("extra_acks", 32'({k0, k1, k2, k3}), 32'hE);
        checkOutput("extra_strobes", 32'(strobeCount - s0), 32'd1);
        checkReport("extra");
        checkAllRegs("extra");

        $display("[TB] out-of-range register");
        doWrite(12, 9'h123, "bad12");

        $display("[TB] reset during second data byte");
        doWrite(4, 9'h0F0, "pre");
        s0 = strobeCount;
        sendStart();
        sendByte(8'h34, k0);
        sendByte(8'h09, k1);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        resetModel();
        checkOutput("midrst_sda", 32'(sdaBus), 32'h1);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        readAck(k2);
        sendStop();
        checkOutput("midrst_acks", 32'({k0, k1, k2}), 32'h6);
        checkOutput("midrst_strobes", 32'(strobeCount - s0), 32'd0);
        checkReport("midrst");
        checkAllRegs("midrst");

        $display("[TB] randomized transfers");
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == 7'h1A) a7 = 7'h2B;
                s0 = strobeCount; d0 = driveCount;
                applyStimulus({a7, 1'($urandom_range(0, 1))}, 8'($urandom), 8'($urandom), acks);
                checkOutput($sformatf("rnd%0d_fAcks", it), 32'(acks), 32'h0);
                checkOutput($sformatf("rnd%0d_fDrive", it), 32'(driveCount - d0), 32'd0);
                checkOutput($sformatf("rnd%0d_fStrobes", it), 32'(strobeCount - s0), 32'd0);
                checkReport($sformatf("rnd%0d", it));
            end else if (kind == 1) begin
                sendStart();
                sendByte(8'h35, k0);
                sendStop();
                nackModel++;
                checkOutput($sformatf("rnd%0d_rAck", it), 32'(k0), 32'h0);
                checkReport($sformatf("rnd%0d", it));
            end else begin
                r = $urandom_range(0, 15);
                d = 9'($urandom_range(0, 511));
                doWrite(r, d, $sformatf("rnd%0d", it));
            end
        end

        $display("[TB] NACK counter saturation");
        while (nackModel < 258) begin
            sendStart();
            sendByte(8'h35, k0);
            sendStop();
            nackModel++;
        end
        checkOutput("nack_sat", 32'(nackCount), 32'd255);
        checkOutput("nack_sat_ack", 32'(k0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/audio_codec_i2c_responder.md
AUDIO_CODEC_I2C_RESPONDER -- requirements
Module: audio_codec_i2c_responder

Interface
REQ-001 The block SHALL have parameter DEVICE_ADDRESS, default 7'h1A, the 7-bit I2C target address it answers to.
REQ-002 The block SHALL have parameter NUM_REGS, default 10, the number of 9-bit codec registers held (register addresses 0..NUM_REGS-1).
REQ-003 The block SHALL have parameter RESET_REG_ADDR, default 7'h0F, the register address whose write restores all registers to defaults.
REQ-004 The block SHALL have port clk, input, 1 bit, the system clock; it is the only clock.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port I2C_SCLK, input, 1 bit, the I2C clock driven by the external initiator.
REQ-007 The block SHALL have port I2C_SDAT, inout, 1 bit, the I2C data line, driven only to 0 or Z.
REQ-008 The block SHALL have port rd_addr, input, 7 bits, the local register read address.
REQ-009 The block SHALL have port rd_data, output, 9 bits, the combinational read of register rd_addr; 0 if rd_addr >= NUM_REGS.
REQ-010 The block SHALL have port wr_strobe, output, 1 bit, a one-cycle pulse for each accepted register write.
REQ-011 The block SHALL have port wr_addr, output, 7 bits, the register address of the last accepted write.
REQ-012 The block SHALL have port wr_data, output, 9 bits, the data of the last accepted write.
REQ-013 The block SHALL have port nack_count, output, 8 bits, a saturating count of transactions the block NACKed because of its own address (R/W=1).

Function
REQ-014 The block SHALL pass SCL and SDA through 2-flop synchronizers, then detect edges on the synchronized values; every decision SHALL be based on the synchronized values only.
REQ-015 The block SHALL decode START as a synchronized-SDA fall while SCL is high, and STOP as a synchronized-SDA rise while SCL is high.
REQ-016 The block SHALL sample data bits MSB first on each synchronized SCL rising edge.
REQ-017 The block SHALL implement FSM states IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2 and WAIT_STOP.
REQ-018 After 8 bits in ADDR, if addr[7:1]==DEVICE_ADDRESS and R/W=0, the block SHALL go to ADDR_ACK; on an address mismatch it SHALL go to WAIT_STOP without driving SDA.
REQ-019 After 8 bits in ADDR, if the address matches and R/W=1, the block SHALL leave SDA released (NACK), increment nack_count (saturating at 255) and go to WAIT_STOP.
REQ-020 In each ACK state, the block SHALL drive SDA low from the first SCL falling edge after bit 8 until the next SCL falling edge, then release it.
REQ-021 BYTE1 SHALL carry {reg_addr[6:0], data[8]}, and BYTE2 SHALL carry data[7:0].
REQ-022 On the SCL rising edge that samples the last BYTE2 bit, the block SHALL update the register and pulse wr_strobe for exactly one cycle, in the cycle after that edge is detected.
REQ-023 A write to reg_addr >= NUM_REGS, other than RESET_REG_ADDR, SHALL be ACKed and discarded, with no wr_strobe.
REQ-024 A write to RESET_REG_ADDR SHALL load all registers with their defaults and SHALL pulse wr_strobe with that address and data.
REQ-025 After ACK2, any further bytes SHALL be NACKed and the FSM SHALL go to WAIT_STOP; there is no auto-increment.
REQ-026 A START in any state SHALL abort the current transfer without writing and go to ADDR; partial bytes SHALL be discarded.
REQ-027 A STOP in any state SHALL release SDA and go to IDLE.
REQ-028 If START and a data-bit sample are detected in the same cycle, START SHALL take priority.

Reset
REQ-029 On reset the block SHALL force state=IDLE, release SDA (Z), wr_strobe=0, wr_addr=0, wr_data=0 and nack_count=0, clear the synchronizers to 1, and load the register defaults (WM8731 power-on values: 097,097,079,079,00A,008,09F,00A,000,000).
REQ-030 Reset asserted mid-transaction SHALL take effect on the next clk edge; the bus SHALL be ignored until the next START.

Structure
REQ-031 The state enum, the default-value table and the field widths SHALL live in a shared package, audio_codec_i2c_pkg.
REQ-032 The synchronizer and edge detector SHALL be one sub-module, i2c_line_monitor, with outputs scl_rise, scl_fall, start_det and stop_det.

Verification
REQ-033 The bench SHALL send START, 0x34, 0x0E, 0x49, STOP and check three ACKs, one wr_strobe with wr_addr=0x07 and wr_data=0x049, and rd_data(7)=0x049.
REQ-034 The bench SHALL send START, 0x36, ... and check that SDA is never driven, no wr_strobe occurs and the FSM returns to IDLE after STOP.
REQ-035 The bench SHALL send START, 0x35 and check a NACK, nack_count=1 and no SDA drive afterward.
REQ-036 The bench SHALL write reg 4 to 0x1FF, then send START, 0x34, 0x1E, 0x00, STOP, and check that reg 4 reads 0x00A and wr_addr=0x0F.
REQ-037 The bench SHALL send START, 0x34, 0x08, then a repeated START, 0x34, 0x0A, 0x55, STOP, and check reg 4 unchanged by the first sequence and reg 5=0x055, with exactly one strobe.
REQ-038 The bench SHALL assert reset during BYTE2 and check SDA released, no write and rd_data(4)=0x00A.
